// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int ARCH                 = 32;
  localparam int ARB_MAX_WAIT_DEFAULT = 8;

  typedef enum logic {
    ARB_RR   = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } master_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the SRAM ports.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req_in;
  logic                  m0_we_in;
  logic [ADDR_WIDTH-1:0] m0_addr_in;
  logic [DATA_WIDTH-1:0] m0_wdata_in;
  logic                  m0_gnt_out;
  logic                  m0_rvalid_out;
  logic [DATA_WIDTH-1:0] m0_rdata_out;

  logic                  m1_req_in;
  logic                  m1_we_in;
  logic [ADDR_WIDTH-1:0] m1_addr_in;
  logic [DATA_WIDTH-1:0] m1_wdata_in;
  logic                  m1_gnt_out;
  logic                  m1_rvalid_out;
  logic [DATA_WIDTH-1:0] m1_rdata_out;
  logic                  m1_lock_in;

  logic [ADDR_WIDTH-1:0] sram_addr_a_out;
  logic [DATA_WIDTH-1:0] sram_din_a_out;
  logic                  sram_we_a_out;
  logic [ADDR_WIDTH-1:0] sram_addr_b_out;
  logic [DATA_WIDTH-1:0] sram_dout_b_in;

  // Arbiter side
  modport slave (
    input  m0_req_in, m0_we_in, m0_addr_in, m0_wdata_in,
    output m0_gnt_out, m0_rvalid_out, m0_rdata_out,
    input  m1_req_in, m1_we_in, m1_addr_in, m1_wdata_in, m1_lock_in,
    output m1_gnt_out, m1_rvalid_out, m1_rdata_out,
    output sram_addr_a_out, sram_din_a_out, sram_we_a_out, sram_addr_b_out,
    input  sram_dout_b_in
  );

  // Masters plus memory side
  modport master (
    output m0_req_in, m0_we_in, m0_addr_in, m0_wdata_in,
    input  m0_gnt_out, m0_rvalid_out, m0_rdata_out,
    output m1_req_in, m1_we_in, m1_addr_in, m1_wdata_in, m1_lock_in,
    input  m1_gnt_out, m1_rvalid_out, m1_rdata_out,
    input  sram_addr_a_out, sram_din_a_out, sram_we_a_out, sram_addr_b_out,
    output sram_dout_b_in
  );
endinterface

// File: rtl/dmem_arbiter_arb_wait_ctr.sv
// Saturating starvation counter for master 0.
module arb_wait_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt,
  output logic       at_max
);
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  // clear wins; otherwise count up and stick at MAX_WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && cnt < MAX_W)  cnt <= cnt + 8'd1;
  end

  assign at_max = (cnt == MAX_W);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of one SRAM: round-robin with an m1 lock
// mode and a bounded-wait escape for m0.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = ARCH,
  parameter int MAX_WAIT   = ARB_MAX_WAIT_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  arb_state_t            state, state_nxt;
  master_t               last_gnt;
  logic                  gnt0, gnt1;
  logic                  rd0, rd1;
  logic [7:0]            wait_cnt;
  logic                  at_max;
  logic                  force_m0;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .inc    (bus.m0_req_in & ~gnt0),
    .clr    (gnt0),
    .cnt    (wait_cnt),
    .at_max (at_max)
  );

  // a zero count never forces, even if MAX_WAIT is misconfigured to 0
  assign force_m0 = at_max && (wait_cnt != 8'd0);

  // grant decision and next state
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    case (state)
      ARB_RR: begin
        if (bus.m0_req_in && bus.m1_req_in) begin
          gnt0 = (last_gnt == GNT_M1);
          gnt1 = ~gnt0;
        end else begin
          gnt0 = bus.m0_req_in;
          gnt1 = bus.m1_req_in;
        end
        if (gnt1 && bus.m1_lock_in) state_nxt = ARB_LOCK;
      end
      ARB_LOCK: begin
        // m0 only gets in through the starvation escape
        if (bus.m0_req_in && force_m0) gnt0 = 1'b1;
        else                           gnt1 = bus.m1_req_in;
        if (!bus.m1_lock_in) state_nxt = ARB_RR;
      end
      default: state_nxt = ARB_RR;
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // arbitration state and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_RR;
      last_gnt <= GNT_M1;
    end else begin
      state <= state_nxt;
      if (gnt0)      last_gnt <= GNT_M0;
      else if (gnt1) last_gnt <= GNT_M1;
    end
  end

  assign rd0 = gnt0 & ~bus.m0_we_in;
  assign rd1 = gnt1 & ~bus.m1_we_in;

  // capture SRAM read data into the granted master's response register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) rdata0 <= bus.sram_dout_b_in;
      if (rd1) rdata1 <= bus.sram_dout_b_in;
    end
  end

  // SRAM ports follow the winner; m0 drives them when idle
  always_comb begin
    bus.sram_addr_a_out = gnt1 ? bus.m1_addr_in  : bus.m0_addr_in;
    bus.sram_din_a_out  = gnt1 ? bus.m1_wdata_in : bus.m0_wdata_in;
    bus.sram_addr_b_out = gnt1 ? bus.m1_addr_in  : bus.m0_addr_in;
    bus.sram_we_a_out   = (gnt0 & bus.m0_we_in) | (gnt1 & bus.m1_we_in);
  end

  assign bus.m0_gnt_out    = gnt0;
  assign bus.m1_gnt_out    = gnt1;
  assign bus.m0_rvalid_out = rvalid0;
  assign bus.m1_rvalid_out = rvalid1;
  assign bus.m0_rdata_out  = rdata0;
  assign bus.m1_rdata_out  = rdata1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 4 KiB SRAM.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // word-aligned SRAM: sync write on port A, async read on port B
  logic [31:0] mem [0:1023];
  logic        seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[1] <= 32'hDEADBEEF;
      seeded <= 1'b1;
    end else if (bus.sram_we_a_out) begin
      mem[bus.sram_addr_a_out[11:2]] <= bus.sram_din_a_out;
    end
  end
  assign bus.sram_dout_b_in = mem[bus.sram_addr_b_out[11:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_set(input logic req, input logic we, input logic [11:0] a, input logic [31:0] d);
    bus.m0_req_in = req; bus.m0_we_in = we; bus.m0_addr_in = a; bus.m0_wdata_in = d;
  endtask

  task automatic m1_set(input logic req, input logic we, input logic [11:0] a, input logic [31:0] d,
                        input logic lock);
    bus.m1_req_in = req; bus.m1_we_in = we; bus.m1_addr_in = a; bus.m1_wdata_in = d;
    bus.m1_lock_in = lock;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    m0_set(1'b1, 1'b0, 12'h004, 32'h0);
    m1_set(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_gnt0",    32'(bus.m0_gnt_out),    32'd0);
    chk("rst_we",      32'(bus.sram_we_a_out), 32'd0);
    chk("rst_rvalid0", 32'(bus.m0_rvalid_out), 32'd0);
    chk("rst_rdata0",  bus.m0_rdata_out,       32'd0);
    chk("rst_rvalid1", 32'(bus.m1_rvalid_out), 32'd0);
    tick();
    rst = 1'b0;

    // single m0 read
    #1;
    chk("rd_gnt0", 32'(bus.m0_gnt_out), 32'd1);
    chk("rd_gnt1", 32'(bus.m1_gnt_out), 32'd0);
    tick();
    m0_set(1'b0, 1'b0, 12'h004, 32'h0);
    chk("rd_rvalid0", 32'(bus.m0_rvalid_out), 32'd1);
    chk("rd_rdata0",  bus.m0_rdata_out,       32'hDEADBEEF);
    chk("rd_rvalid1", 32'(bus.m1_rvalid_out), 32'd0);
    chk("rd_rdata1",  bus.m1_rdata_out,       32'd0);

    // round-robin alternation, m0 first after reset
    rst_pulse();
    m0_set(1'b1, 1'b1, 12'h020, 32'hA5A50000);
    m1_set(1'b1, 1'b0, 12'h004, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_gnt0_%0d", i), 32'(bus.m0_gnt_out),    32'((i % 2) == 0));
      chk($sformatf("rr_gnt1_%0d", i), 32'(bus.m1_gnt_out),    32'((i % 2) == 1));
      chk($sformatf("rr_we_%0d", i),   32'(bus.sram_we_a_out), 32'((i % 2) == 0));
      tick();
      chk($sformatf("rr_rv1_%0d", i),  32'(bus.m1_rvalid_out), 32'((i % 2) == 1));
    end
    chk("rr_rdata1", bus.m1_rdata_out, 32'hDEADBEEF);
    m0_set(1'b0, 1'b0, 12'h000, 32'h0);

    // write then read-after-write from the other master
    m1_set(1'b1, 1'b1, 12'h010, 32'h12345678, 1'b0);
    #1;
    chk("raw_gnt1",  32'(bus.m1_gnt_out),    32'd1);
    chk("raw_we",    32'(bus.sram_we_a_out), 32'd1);
    chk("raw_addra", 32'(bus.sram_addr_a_out), 32'h010);
    tick();
    m1_set(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
    m0_set(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    chk("raw_gnt0", 32'(bus.m0_gnt_out), 32'd1);
    tick();
    m0_set(1'b0, 1'b0, 12'h000, 32'h0);
    chk("raw_rdata0", bus.m0_rdata_out, 32'h12345678);

    // lock with m1 streaming writes; m0 forced through on its 9th request cycle
    rst_pulse();
    m1_set(1'b1, 1'b1, 12'h100, 32'h0, 1'b1);
    #1;
    chk("lk_enter_gnt1", 32'(bus.m1_gnt_out), 32'd1);
    tick();
    chk("lk_state", 32'(dut.state), 32'(ARB_LOCK));
    m0_set(1'b1, 1'b0, 12'h004, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      bus.m1_wdata_in = 32'(c);
      #1;
      chk($sformatf("lk_gnt0_%0d", c), 32'(bus.m0_gnt_out), 32'(c == 9));
      chk($sformatf("lk_gnt1_%0d", c), 32'(bus.m1_gnt_out), 32'(c != 9));
      tick();
    end
    m0_set(1'b0, 1'b0, 12'h000, 32'h0);
    chk("lk_rvalid0", 32'(bus.m0_rvalid_out), 32'd1);
    chk("lk_rdata0",  bus.m0_rdata_out,       32'hDEADBEEF);
    #1;
    chk("lk_resume_gnt1", 32'(bus.m1_gnt_out), 32'd1);
    tick();

    // lock held with m1 idle: m0 waits 8 cycles, then a forced grant
    m1_set(1'b0, 1'b0, 12'h100, 32'h0, 1'b1);
    m0_set(1'b1, 1'b0, 12'h010, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      #1;
      chk($sformatf("idle_gnt0_%0d", c), 32'(bus.m0_gnt_out), 32'(c == 9));
      chk($sformatf("idle_gnt1_%0d", c), 32'(bus.m1_gnt_out), 32'd0);
      tick();
    end
    chk("idle_rdata0", bus.m0_rdata_out, 32'h12345678);
    m0_set(1'b0, 1'b0, 12'h000, 32'h0);
    bus.m1_lock_in = 1'b0;
    tick();
    chk("unlock_state", 32'(dut.state), 32'(ARB_RR));
    // last grant was the forced m0 one, so m1 wins the tie, then m0
    m0_set(1'b1, 1'b0, 12'h004, 32'h0);
    m1_set(1'b1, 1'b0, 12'h004, 32'h0, 1'b0);
    #1;
    chk("unlock_gnt1", 32'(bus.m1_gnt_out), 32'd1);
    tick();
    #1;
    chk("unlock_gnt0", 32'(bus.m0_gnt_out), 32'd1);
    tick();
    m0_set(1'b0, 1'b0, 12'h000, 32'h0);
    m1_set(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);

    // reset while locked with a partly elapsed wait
    m1_set(1'b1, 1'b1, 12'h100, 32'h0, 1'b1);
    tick();
    bus.m1_req_in = 1'b0;
    m0_set(1'b1, 1'b0, 12'h004, 32'h0);
    tick(); tick(); tick();
    chk("mid_wait_pre",  32'(dut.wait_cnt), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_state",    32'(dut.state),      32'(ARB_RR));
    chk("mid_wait",     32'(dut.wait_cnt),   32'd0);
    chk("mid_gnt0",     32'(bus.m0_gnt_out), 32'd0);
    rst = 1'b0;
    m0_set(1'b0, 1'b0, 12'h000, 32'h0);
    bus.m1_lock_in = 1'b0;
    tick();

    // reset right after an m0 read grant drops the response
    m0_set(1'b1, 1'b0, 12'h004, 32'h0);
    #1;
    chk("rrst_gnt0", 32'(bus.m0_gnt_out), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rrst_rvalid0", 32'(bus.m0_rvalid_out), 32'd0);
    chk("rrst_rdata0",  bus.m0_rdata_out,       32'd0);
    m0_set(1'b0, 1'b0, 12'h000, 32'h0);
    rst = 1'b0;
    tick();
    chk("rrst_rvalid0_after", 32'(bus.m0_rvalid_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop so the run always ends
  initial begin
    #20000;
    bad++;
    $display("FAIL timeout obs=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
